// File: rtl/uart_host_link.sv
// rtl/uart_host_link.sv - host-side UART endpoint: sends two operands, waits for one result byte
module uart_host_link #(
  parameter int CLKS_PER_BIT   = 10417,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       timeout
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LP_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LP_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_TX_OP1   = 2'd1;
  localparam logic [1:0] S_TX_OP2   = 2'd2;
  localparam logic [1:0] S_WAIT_RES = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [7:0]    r_op1;
  logic [7:0]    r_op2;
  logic [CW-1:0] r_tx_clk;
  logic [3:0]    r_tx_bit;
  logic          r_uart_tx;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic [7:0]    r_result;
  logic [TW-1:0] r_to_cnt;

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_rx_clk;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;

  logic [7:0]    w_cur_op;
  logic          w_next_bit;
  logic          w_rx_valid;

  assign uart_tx = r_uart_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign timeout = r_timeout;

  // Line level for the bit after the current one: data bits d0..d7, then the stop bit.
  always_comb begin
    w_cur_op   = (r_state == S_TX_OP1) ? r_op1 : r_op2;
    w_next_bit = 1'b1;
    if (r_tx_bit < 4'd8) begin
      w_next_bit = w_cur_op[r_tx_bit[2:0]];
    end
  end

  // A frame is good when the stop-bit centre sample is high.
  assign w_rx_valid = (r_rx_state == RX_STOP) && (r_rx_clk == LP_BIT_LAST) && r_rx_s2;

  // Transaction FSM: transmits op1/op2 back to back, then waits for result or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op1     <= 8'h00;
      r_op2     <= 8'h00;
      r_tx_clk  <= '0;
      r_tx_bit  <= 4'd0;
      r_uart_tx <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_result  <= 8'h00;
      r_to_cnt  <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op1     <= op1;
            r_op2     <= op2;
            r_tx_clk  <= '0;
            r_tx_bit  <= 4'd0;
            r_uart_tx <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_TX_OP1;
          end
        end
        S_TX_OP1, S_TX_OP2: begin
          if (r_tx_clk == LP_BIT_LAST) begin
            r_tx_clk <= '0;
            if (r_tx_bit == 4'd9) begin
              r_tx_bit <= 4'd0;
              if (r_state == S_TX_OP1) begin
                r_uart_tx <= 1'b0;
                r_state   <= S_TX_OP2;
              end else begin
                r_uart_tx <= 1'b1;
                r_to_cnt  <= '0;
                r_state   <= S_WAIT_RES;
              end
            end else begin
              r_tx_bit  <= r_tx_bit + 4'd1;
              r_uart_tx <= w_next_bit;
            end
          end else begin
            r_tx_clk <= r_tx_clk + 1'b1;
          end
        end
        default: begin
          // A good frame in the same cycle as expiry takes priority.
          if (w_rx_valid) begin
            r_result <= r_rx_shift;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_to_cnt == LP_TO_LAST) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Free-running receiver: start-bit recheck at half period, then centre sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_clk   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2 && r_rx_prev) begin
            r_rx_clk   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_clk == LP_HALF_LAST) begin
            r_rx_clk   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_clk <= r_rx_clk + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_clk == LP_BIT_LAST) begin
            r_rx_clk   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_clk <= r_rx_clk + 1'b1;
          end
        end
        default: begin
          // Re-arm at the stop-bit centre whether or not the frame was good.
          if (r_rx_clk == LP_BIT_LAST) begin
            r_rx_clk   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_clk <= r_rx_clk + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_link.sv
// tb/tb_uart_host_link.sv - self-checking bench for uart_host_link
module tb_uart_host_link;

  localparam int CPB = 16;
  localparam int TO  = 1000;

  typedef struct {
    logic [7:0] op1;
    logic [7:0] op2;
    logic       send;
    logic [7:0] rx;
    int         delay;
    logic       exp_done;
    logic [7:0] exp_res;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op1 = 8'h00;
  logic [7:0] op2 = 8'h00;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int done_cyc = 0;
  int to_cyc = 0;
  logic busy_at_evt = 1'b1;

  always #5 clk = ~clk;

  uart_host_link #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .busy(busy), .done(done),
    .result(result), .timeout(timeout)
  );

  always @(posedge clk) begin
    #1;
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_evt = busy;
    end
    if (timeout === 1'b1) begin
      to_cnt++;
      to_cyc = cyc;
      busy_at_evt = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected summary first");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [19:0] frame_bits(input logic [7:0] a, input logic [7:0] b);
    return {1'b1, b, 1'b0, 1'b1, a, 1'b0};
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_tx(input string name, input logic [19:0] exp);
    int err = 0;
    int berr = 0;
    for (int k = 0; k < 20 * CPB; k++) begin
      if (uart_tx !== exp[k / CPB]) err++;
      if (busy !== 1'b1) berr++;
      if (k % CPB == CPB - 1) begin
        chk($sformatf("%s_bit%0d_bad_cycles", name, k / CPB), err, 0);
        err = 0;
      end
      @(negedge clk);
    end
    chk({name, "_busy_low_cycles"}, berr, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, output int t0);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_evt(input string name, input int budget);
    int d0 = done_cnt;
    int t0 = to_cnt;
    int n = 0;
    while (done_cnt == d0 && to_cnt == t0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_event_seen"}, (done_cnt != d0) || (to_cnt != t0), 1'b1);
  endtask

  vec_t vecs [5];
  logic exp_seq [20];
  logic [19:0] lit;
  int y, d0, t0, rxs, mid, err;

  initial begin
    vecs[0] = '{8'h00, 8'hFF, 1'b0, 8'h00, 0,   1'b0, 8'hE1};
    vecs[1] = '{8'h5A, 8'h81, 1'b1, 8'h3C, 200, 1'b1, 8'h3C};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 0,   1'b1, 8'h00};
    vecs[3] = '{8'h96, 8'h69, 1'b1, 8'hC7, 800, 1'b1, 8'hC7};
    vecs[4] = '{8'h01, 8'h80, 1'b0, 8'h00, 0,   1'b0, 8'hC7};
    exp_seq = '{0,1,0,1,0,0,1,0,1,1, 0,0,0,1,1,1,1,0,0,1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_result", result, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic send plus result capture 50 cycles after WAIT_RES entry
    for (int i = 0; i < 20; i++) lit[i] = exp_seq[i];
    launch(8'hA5, 8'h3C);
    check_tx("basic", lit);
    d0 = done_cnt;
    t0 = to_cnt;
    fork
      begin repeat (50) @(negedge clk); send_rx(8'hE1, 1'b1, rxs); end
      wait_evt("basic", 1200);
    join
    repeat (20) @(negedge clk);
    chk("basic_done_count", done_cnt - d0, 1);
    chk("basic_no_timeout", to_cnt - t0, 0);
    chk("basic_result", result, 8'hE1);
    chk("basic_busy_at_done", busy_at_evt, 1'b0);
    chk_range("basic_done_latency", done_cyc - rxs, 152, 158);

    // Table of transactions
    foreach (vecs[i]) begin
      launch(vecs[i].op1, vecs[i].op2);
      check_tx($sformatf("v%0d", i), frame_bits(vecs[i].op1, vecs[i].op2));
      y = cyc;
      d0 = done_cnt;
      t0 = to_cnt;
      rxs = 0;
      fork
        begin
          if (vecs[i].send) begin
            repeat (vecs[i].delay) @(negedge clk);
            send_rx(vecs[i].rx, 1'b1, rxs);
          end
        end
        wait_evt($sformatf("v%0d", i), 1200);
      join
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_done_count", i), done_cnt - d0, {31'd0, vecs[i].exp_done});
      chk($sformatf("v%0d_timeout_count", i), to_cnt - t0, {31'd0, !vecs[i].exp_done});
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d_busy_at_event", i), busy_at_evt, 1'b0);
      chk($sformatf("v%0d_busy_after", i), busy, 1'b0);
      if (vecs[i].exp_done)
        chk_range($sformatf("v%0d_done_latency", i), done_cyc - rxs, 152, 158);
      else
        chk($sformatf("v%0d_timeout_cycle", i), to_cyc - y, TO);
    end

    // Framing error, then a good frame
    launch(8'h11, 8'h22);
    check_tx("frame", frame_bits(8'h11, 8'h22));
    d0 = done_cnt;
    t0 = to_cnt;
    mid = 0;
    fork
      begin
        repeat (30) @(negedge clk);
        send_rx(8'h55, 1'b0, rxs);
        repeat (20) @(negedge clk);
        mid = done_cnt;
        send_rx(8'h0F, 1'b1, rxs);
      end
      wait_evt("frame", 1200);
    join
    repeat (20) @(negedge clk);
    chk("frame_err_no_done", mid - d0, 0);
    chk("frame_done_count", done_cnt - d0, 1);
    chk("frame_no_timeout", to_cnt - t0, 0);
    chk("frame_result", result, 8'h0F);

    // Stray frame during TX_OP1, then a glitch, then a good frame
    launch(8'h33, 8'h44);
    d0 = done_cnt;
    t0 = to_cnt;
    fork
      check_tx("stray", frame_bits(8'h33, 8'h44));
      begin repeat (10) @(negedge clk); send_rx(8'h77, 1'b1, rxs); end
    join
    chk("stray_no_done", done_cnt - d0, 0);
    chk("stray_result_kept", result, 8'h0F);
    mid = 0;
    fork
      begin
        repeat (20) @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (80) @(negedge clk);
        mid = done_cnt;
        send_rx(8'h12, 1'b1, rxs);
      end
      wait_evt("glitch", 1200);
    join
    repeat (20) @(negedge clk);
    chk("glitch_no_done", mid - d0, 0);
    chk("glitch_done_count", done_cnt - d0, 1);
    chk("glitch_no_timeout", to_cnt - t0, 0);
    chk("glitch_result", result, 8'h12);

    // Start pulse during TX_OP2 is ignored
    launch(8'hC3, 8'h5E);
    d0 = done_cnt;
    t0 = to_cnt;
    fork
      check_tx("bstart", frame_bits(8'hC3, 8'h5E));
      begin
        repeat (200) @(negedge clk);
        op1 = 8'hFF;
        op2 = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    y = cyc;
    wait_evt("bstart", 1200);
    repeat (20) @(negedge clk);
    chk("bstart_timeout_cycle", to_cyc - y, TO);
    chk("bstart_no_done", done_cnt - d0, 0);
    chk("bstart_result_kept", result, 8'h12);
    chk("bstart_idle_busy", busy, 1'b0);
    chk("bstart_idle_line", uart_tx, 1'b1);

    // Reset in the middle of op1 bit d3
    launch(8'hA5, 8'h3C);
    repeat (4 * CPB + 6) @(negedge clk);
    chk("mrst_pre_line_d3", uart_tx, 1'b0);
    chk("mrst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_uart_tx", uart_tx, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_result", result, 8'h00);
    chk("mrst_done", done, 1'b0);
    chk("mrst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    err = 0;
    repeat (40) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) err++;
    end
    chk("mrst_stays_idle_bad_cycles", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_host_link.md
# uart_host_link

Host-side UART endpoint for the pipelined CPU's operand/result protocol. It serialises two 8-bit operands onto the line the CPU receives on, then waits for the CPU's one-byte result on the CPU's transmit line and presents it in parallel. It sits on the host or test FPGA, or in the system bench, facing the CPU's UART pins.

## Interface
Parameters:
- CLKS_PER_BIT, 10417: clock cycles per UART bit (100 MHz / 9600 baud); minimum 4.
- TIMEOUT_CYCLES, 2000000: cycles allowed in WAIT_RES before giving up.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a transaction; sampled only in IDLE.
- op1  in  8  first operand; sent first.
- op2  in  8  second operand; sent second.
- uart_tx  out  1  serial line to the CPU's uart_rx.
- uart_rx  in  1  serial line from the CPU's uart_tx.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse when a valid result byte has been captured.
- result  out  8  last captured result byte.
- timeout  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.

## Operation
- Frame format is 8N1: idle high, one start bit (0), 8 data bits LSB first, one stop bit (1).
- FSM states are IDLE, TX_OP1, TX_OP2 and WAIT_RES.
- IDLE, with start=1: latch op1 and op2, then go to TX_OP1. While busy, start is ignored.
- TX_OP1: send the frame for op1. At the end of its stop bit, go to TX_OP2 with no idle gap.
- TX_OP2: send the frame for op2. At the end of its stop bit, go to WAIT_RES and clear the timeout counter.
- WAIT_RES, on a valid received frame: load result, pulse done, go to IDLE.
- WAIT_RES, when the counter reaches TIMEOUT_CYCLES: pulse timeout, leave result unchanged, go to IDLE.
- Transmitter: a bit-period counter counts 0..CLKS_PER_BIT-1. A bit index counts 0..9 (start, d0..d7, stop). uart_tx is registered.
- Receiver:
  - uart_rx passes through a 2-flop synchroniser.
  - The receiver runs in every state. Frames that complete outside WAIT_RES are discarded.
  - It detects the falling edge of the synchronised line while the receiver is idle.
  - It re-checks the start bit at CLKS_PER_BIT/2 (integer division). If the line is high, the event is a glitch: return to receiver idle.
  - It samples the data bits at the centre of each bit, every CLKS_PER_BIT cycles after the start-bit centre.
  - Stop-bit check at its centre:
    - Stop = 0 is a framing error. Discard the byte, do not pulse done, and stay in WAIT_RES. The timeout counter keeps running.
    - Stop = 1 makes the frame valid. The receiver re-arms immediately at the stop-bit centre.
- Reset, including mid-frame:
  - uart_tx=1, busy=0, done=0, timeout=0, result=8'h00.
  - FSM returns to IDLE; all counters and the synchroniser go to idle (synchroniser flops reset to 1).
  - A frame that was partly transmitted is truncated: the line simply goes high.

## Timing
- start=1 sampled at edge T0:
  - busy=1 and uart_tx=0 from T0+1.
  - The op1 start bit occupies T0+1 .. T0+CLKS_PER_BIT.
  - The op2 start bit begins at T0+1+10·CLKS_PER_BIT.
  - Entry into WAIT_RES is at T0+1+20·CLKS_PER_BIT.
- busy falls in the same cycle that done or timeout is high.
- start may be reasserted in the cycle after that, and is accepted then.
- done rises 1 cycle after the stop-bit centre sample; the latency includes the 2-cycle synchroniser.
- result changes in the same cycle that done rises and holds until the next done.
- done and timeout are mutually exclusive. If the valid-stop sample and timeout expiry fall in the same cycle, done wins.
- Maximum transaction length: 20·CLKS_PER_BIT + TIMEOUT_CYCLES + 1 cycles.

## Test plan
Run all scenarios with CLKS_PER_BIT=16 and TIMEOUT_CYCLES=1000.
- Basic send:
  - Stimulus: op1=8'hA5, op2=8'h3C, start pulsed.
  - Required: uart_tx shows 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1, 16 cycles per bit, no gap between frames.
- Result capture:
  - Stimulus: a bench UART drives 8'hE1 on uart_rx 50 cycles after WAIT_RES entry.
  - Required: done pulses once, result=8'hE1, busy drops in the done cycle.
- Framing error, then good frame:
  - Stimulus: a frame 8'h55 with stop=0, followed by a valid 8'h0F.
  - Required: no done for 8'h55; done with result=8'h0F.
- Timeout:
  - Stimulus: no rx activity.
  - Required: timeout pulses exactly 1000 cycles after WAIT_RES entry, result unchanged, busy=0.
- Glitch and stray frame:
  - Stimulus: a 3-cycle low pulse on uart_rx during WAIT_RES, then an 8'h77 frame sent during TX_OP1.
  - Required: neither event produces done; a later valid 8'h12 gives result=8'h12.
- Reset mid-transaction and start while busy:
  - Stimulus: rst asserted mid-way through op1 bit d3; separately, start pulsed during TX_OP2.
  - Required: after rst, uart_tx=1, busy=0, result=8'h00 within the reset cycle. The start pulse during TX_OP2 is ignored, and the operands on the line are unchanged.
